// File: rtl/product_accumulator_pkg.sv
// Shared types and width constants for the product accumulator slice.
package product_accumulator_pkg;

   localparam int unsigned PROD_W    = 64;
   localparam int unsigned DEF_ACC_W = 80;
   localparam int unsigned DEF_CNT_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } state_t;

endpackage

// File: rtl/acc_sat_add.sv
// Combinational sign-extending accumulate with signed-overflow detect.
// With ACC_SATURATE_EN defined an overflowing add clamps to the signed limit.
module acc_sat_add
   import product_accumulator_pkg::*;
#(
   parameter int unsigned ACC_W = DEF_ACC_W
) (
   input  logic [ACC_W-1:0]  acc,
   input  logic [PROD_W-1:0] product,
   output logic [ACC_W-1:0]  sum_c,
   output logic              ovf_c
);

   logic [ACC_W-1:0] ext;
   logic [ACC_W-1:0] raw;

   always_comb begin
      ext   = ACC_W'($signed(product));
      raw   = acc + ext;
      // overflow: operands share a sign that the raw sum does not
      ovf_c = (acc[ACC_W-1] == ext[ACC_W-1]) && (raw[ACC_W-1] != acc[ACC_W-1]);
      sum_c = raw;
`ifdef ACC_SATURATE_EN
      if (ovf_c) begin
         sum_c = acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
`else
      sum_c = raw;
`endif
   end

endmodule

// File: rtl/product_accumulator.sv
// Accumulates signed 64-bit products into groups delimited by in_last.
// Optional clamping on overflow is selected by the ACC_SATURATE_EN macro.
module product_accumulator
   import product_accumulator_pkg::*;
#(
   parameter int unsigned ACC_W = DEF_ACC_W,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [PROD_W-1:0] product,
   input  logic              in_last,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ACC_W-1:0]  acc_out,
   output logic [CNT_W-1:0]  term_cnt,
   output logic              ovf
);

   state_t           state;
   state_t           state_nxt;
   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] sum_c;
   logic             add_ovf_c;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             sticky;
   logic             in_xfer;
   logic             out_xfer;

   acc_sat_add #(.ACC_W(ACC_W)) u_add (
      .acc     (acc),
      .product (product),
      .sum_c   (sum_c),
      .ovf_c   (add_ovf_c)
   );

   assign in_xfer  = in_valid & in_ready;
   assign out_xfer = out_valid & out_ready;
   // term counter sticks at all-ones instead of wrapping
   assign cnt_inc  = (&cnt) ? cnt : cnt + CNT_W'(1);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, ACCUM: begin
            if (in_xfer) begin
               state_nxt = in_last ? HOLD : ACCUM;
            end
         end
         HOLD: begin
            if (out_xfer) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      in_ready = 1'b1;
      if (state == HOLD) begin
         in_ready = 1'b0;
      end
   end

   // Accumulator, counter and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         acc       <= '0;
         cnt       <= '0;
         sticky    <= 1'b0;
         out_valid <= 1'b0;
         acc_out   <= '0;
         term_cnt  <= '0;
         ovf       <= 1'b0;
      end else if (in_xfer) begin
         if (in_last) begin
            acc_out   <= sum_c;
            term_cnt  <= cnt_inc;
            ovf       <= sticky | add_ovf_c;
            out_valid <= 1'b1;
         end else begin
            acc    <= sum_c;
            cnt    <= cnt_inc;
            sticky <= sticky | add_ovf_c;
         end
      end else if (out_xfer) begin
         // result consumed: clear the running group for the next one
         out_valid <= 1'b0;
         acc       <= '0;
         cnt       <= '0;
         sticky    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: a wide instance (80/16) and a
// narrow instance (64/2) for the overflow and counter-saturation corners.
module tb_product_accumulator;

   typedef struct {
      logic [127:0] acc;
      logic [15:0]  cnt;
      logic         o;
   } exp_t;

   logic        clk;
   logic        rst;

   logic        in_valid0, in_ready0, in_last0, out_valid0, out_ready0, ovf0;
   logic [63:0] product0;
   logic [79:0] acc_out0;
   logic [15:0] term_cnt0;

   logic        in_valid1, in_ready1, in_last1, out_valid1, out_ready1, ovf1;
   logic [63:0] product1;
   logic [63:0] acc_out1;
   logic [1:0]  term_cnt1;

   logic        rand_en, force_rdy0, rnd_rdy, use_model;

   exp_t q0[$];
   exp_t q1[$];

   int n_cmp = 0;
   int n_err = 0;

   logic signed [127:0] m_acc [2];
   int                  m_cnt [2];
   logic                m_st  [2];
   int                  accw  [2] = '{80, 64};
   int                  cmax  [2] = '{65535, 3};

   product_accumulator #(.ACC_W(80), .CNT_W(16)) dut0 (
      .clk(clk), .rst(rst), .in_valid(in_valid0), .in_ready(in_ready0),
      .product(product0), .in_last(in_last0), .out_valid(out_valid0),
      .out_ready(out_ready0), .acc_out(acc_out0), .term_cnt(term_cnt0), .ovf(ovf0)
   );

   product_accumulator #(.ACC_W(64), .CNT_W(2)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
      .product(product1), .in_last(in_last1), .out_valid(out_valid1),
      .out_ready(out_ready1), .acc_out(acc_out1), .term_cnt(term_cnt1), .ovf(ovf1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) rnd_rdy <= ($urandom_range(0, 3) != 0);
   assign out_ready0 = rand_en ? rnd_rdy : force_rdy0;
   assign out_ready1 = 1'b1;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference add in an accw-bit signed accumulator, via range checks
   function automatic logic signed [127:0] madd(input logic signed [127:0] a,
                                                input logic signed [63:0] p,
                                                input int w, output logic o);
      logic signed [127:0] s, mx, mn;
      mx = (128'sd1 <<< (w - 1)) - 128'sd1;
      mn = -mx - 128'sd1;
      s  = a + 128'(p);
      o  = (s > mx) || (s < mn);
`ifdef ACC_SATURATE_EN
      if (o) s = (s > mx) ? mx : mn;
`else
      if (o) s = (s <<< (128 - w)) >>> (128 - w);
`endif
      return s;
   endfunction

   task automatic model_clear(input int u);
      m_acc[u] = '0;
      m_cnt[u] = 0;
      m_st[u]  = 1'b0;
   endtask

   task automatic push_exp(input int u, input logic [127:0] a, input int c, input logic o);
      exp_t e;
      e.acc = a;
      e.cnt = 16'(c);
      e.o   = o;
      if (u == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic sync;
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+1 after the accepting edge
   task automatic send(input int u, input logic [63:0] p, input logic l, output int waited);
      logic r;
      logic o;
      int   t;
      t = 0;
      if (u == 0) begin in_valid0 = 1'b1; product0 = p; in_last0 = l; end
      else        begin in_valid1 = 1'b1; product1 = p; in_last1 = l; end
      forever begin
         @(negedge clk);
         r = (u == 0) ? in_ready0 : in_ready1;
         @(posedge clk);
         if (r) break;
         t++;
         if (t > 1000) begin
            n_cmp++;
            n_err++;
            $display("FAIL send timeout: unit %0d never ready after %0d cycles", u, t);
            break;
         end
      end
      #1;
      if (u == 0) in_valid0 = 1'b0;
      else        in_valid1 = 1'b0;
      waited = t;
      if (r) begin
         m_acc[u] = madd(m_acc[u], p, accw[u], o);
         m_st[u]  = m_st[u] | o;
         if (m_cnt[u] != cmax[u]) m_cnt[u] = m_cnt[u] + 1;
         if (l) begin
            if (use_model) push_exp(u, m_acc[u], m_cnt[u], m_st[u]);
            model_clear(u);
         end
      end
   endtask

   task automatic do_reset;
      rst = 1'b1;
      sync();
      rst = 1'b0;
      q0.delete();
      q1.delete();
      model_clear(0);
      model_clear(1);
   endtask

   task automatic wait_drain(input int u, input string nm);
      int t;
      t = 0;
      while (((u == 0) ? q0.size() : q1.size()) > 0 && t < 500) begin
         @(posedge clk);
         t++;
      end
      #1;
      chk(nm, 128'((u == 0) ? q0.size() : q1.size()), 128'd0);
      sync();
   endtask

   // Monitors: pop and compare on every output transfer
   always @(negedge clk) begin
      exp_t e;
      if (out_valid0 && out_ready0 && !rst) begin
         if (q0.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL dut0 unexpected output: acc %0h cnt %0d", acc_out0, term_cnt0);
         end else begin
            e = q0.pop_front();
            chk("dut0 acc_out", 128'(acc_out0), 128'(e.acc[79:0]));
            chk("dut0 term_cnt", 128'(term_cnt0), 128'(e.cnt));
            chk("dut0 ovf", 128'(ovf0), 128'(e.o));
         end
      end
   end

   always @(negedge clk) begin
      exp_t e;
      if (out_valid1 && out_ready1 && !rst) begin
         if (q1.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL dut1 unexpected output: acc %0h cnt %0d", acc_out1, term_cnt1);
         end else begin
            e = q1.pop_front();
            chk("dut1 acc_out", 128'(acc_out1), 128'(e.acc[63:0]));
            chk("dut1 term_cnt", 128'(term_cnt1), 128'(e.cnt[1:0]));
            chk("dut1 ovf", 128'(ovf1), 128'(e.o));
         end
      end
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int w;
      int left;
      logic signed [31:0] a, b;
      logic [63:0] p;

      rst = 1'b1;
      in_valid0 = 1'b0; in_last0 = 1'b0; product0 = '0;
      in_valid1 = 1'b0; in_last1 = 1'b0; product1 = '0;
      rand_en = 1'b0; force_rdy0 = 1'b1; use_model = 1'b0;
      model_clear(0);
      model_clear(1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk("reset in_ready", 128'(in_ready0), 128'd1);
      chk("reset out_valid", 128'(out_valid0), 128'd0);
      chk("reset acc_out", 128'(acc_out0), 128'd0);
      chk("reset term_cnt", 128'(term_cnt0), 128'd0);
      chk("reset ovf", 128'(ovf0), 128'd0);
      sync();

      // 3, -5, 10 -> 8 / 3; out_valid for exactly one cycle
      send(0, 64'd3, 1'b0, w);
      send(0, -64'sd5, 1'b0, w);
      send(0, 64'd10, 1'b1, w);
      push_exp(0, 128'd8, 3, 1'b0);
      @(negedge clk);
      chk("sum latency out_valid", 128'(out_valid0), 128'd1);
      @(negedge clk);
      chk("one-cycle out_valid", 128'(out_valid0), 128'd0);
      chk("ready after output", 128'(in_ready0), 128'd1);
      sync();

      // -2^63 held under back-pressure
      force_rdy0 = 1'b0;
      send(0, 64'h8000_0000_0000_0000, 1'b1, w);
      push_exp(0, 128'hFFFF_8000_0000_0000_0000, 1, 1'b0);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("hold in_ready", 128'(in_ready0), 128'd0);
         chk("hold out_valid", 128'(out_valid0), 128'd1);
         chk("hold acc_out", 128'(acc_out0), 128'hFFFF_8000_0000_0000_0000);
         chk("hold term_cnt", 128'(term_cnt0), 128'd1);
      end
      sync();
      force_rdy0 = 1'b1;
      sync();
      send(0, 64'd0, 1'b1, w);
      chk("accept after release", 128'(w), 128'd0);
      push_exp(0, 128'd0, 1, 1'b0);
      wait_drain(0, "drain after hold");

      // Pending result discarded by reset
      force_rdy0 = 1'b0;
      send(0, 64'd5, 1'b1, w);
      do_reset();
      @(negedge clk);
      chk("reset drops pending", 128'(out_valid0), 128'd0);
      chk("reset ready", 128'(in_ready0), 128'd1);
      sync();
      force_rdy0 = 1'b1;

      // Partial group 2, 4 discarded by reset, then 7 alone
      send(0, 64'd2, 1'b0, w);
      send(0, 64'd4, 1'b0, w);
      do_reset();
      send(0, 64'd7, 1'b1, w);
      push_exp(0, 128'd7, 1, 1'b0);
      wait_drain(0, "drain after reset");

      // 80-bit accumulator absorbs 2^63 without overflow
      send(0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, w);
      send(0, 64'd1, 1'b1, w);
      push_exp(0, 128'h8000_0000_0000_0000, 2, 1'b0);
      wait_drain(0, "drain wide");

      // 64-bit accumulator: positive overflow on the final add
      send(1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, w);
      send(1, 64'd1, 1'b1, w);
`ifdef ACC_SATURATE_EN
      push_exp(1, 128'h7FFF_FFFF_FFFF_FFFF, 2, 1'b1);
`else
      push_exp(1, 128'h8000_0000_0000_0000, 2, 1'b1);
`endif
      // Overflow mid-group must stay sticky through a harmless final add
      send(1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, w);
      send(1, 64'd1, 1'b0, w);
      send(1, 64'd0, 1'b1, w);
`ifdef ACC_SATURATE_EN
      push_exp(1, 128'h7FFF_FFFF_FFFF_FFFF, 3, 1'b1);
`else
      push_exp(1, 128'h8000_0000_0000_0000, 3, 1'b1);
`endif
      // Negative overflow
      send(1, 64'h8000_0000_0000_0000, 1'b0, w);
      send(1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, w);
`ifdef ACC_SATURATE_EN
      push_exp(1, 128'h8000_0000_0000_0000, 2, 1'b1);
`else
      push_exp(1, 128'h7FFF_FFFF_FFFF_FFFF, 2, 1'b1);
`endif
      // 2-bit counter saturates at 3
      for (int i = 0; i < 5; i++) send(1, 64'd1, (i == 4), w);
      push_exp(1, 128'd5, 3, 1'b0);
      wait_drain(1, "drain narrow");

      // 1000 products of 32x32 signed multiplies with random gaps
      use_model = 1'b1;
      rand_en   = 1'b1;
      left = 0;
      for (int i = 0; i < 1000; i++) begin
         if (left == 0) left = $urandom_range(1, 8);
         repeat ($urandom_range(0, 2)) begin
            product0 = {$urandom, $urandom};
            in_last0 = 1'($urandom_range(0, 1));
            sync();
         end
         a = $urandom;
         b = $urandom;
         p = 64'(64'(a) * 64'(b));
         send(0, p, (left == 1) || (i == 999), w);
         left--;
      end
      wait_drain(0, "drain random");
      rand_en = 1'b0;

      chk("q0 empty", 128'(q0.size()), 128'd0);
      chk("q1 empty", 128'(q1.size()), 128'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
